// File: rtl/win_addr_scan.sv
// Window address scanner: walks a 16x16 offset window around a keypoint, reads
// the external dx/dy offset ROMs and emits clamped absolute sample coordinates.
module win_addr_scan #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] kp_x,
  input  logic [CW-1:0] kp_y,
  output logic [7:0]    rom_addr,
  input  logic [4:0]    dx_off,
  input  logic [4:0]    dy_off,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic [7:0]    out_idx,
  output logic          out_inb,
  output logic          busy,
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for start; rom_addr held at 0
  // SCAN  | counter drives rom_addr, one beat loaded per advance
  // FLUSH | index 255 is in the output register, waiting for its handshake
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  localparam logic signed [CW+1:0] X_MAX = (CW+2)'(IMG_W - 1);
  localparam logic signed [CW+1:0] Y_MAX = (CW+2)'(IMG_H - 1);

  state_t state, state_nxt;

  logic [7:0]    cnt;
  logic [CW-1:0] kx, ky;
  logic          advance, handshake;

  logic signed [CW+1:0] sx, sy;
  logic [CW-1:0]        cx, cy;
  logic                 inb_x, inb_y;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_addr  = 8'd0;
    advance   = 1'b0;
    handshake = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        rom_addr = cnt;
        advance  = !out_valid || out_ready;
        if (advance && cnt == 8'hFF) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offsets are sign-extended so a keypoint near the edge can go negative.
  always_comb begin
    sx = $signed({2'b00, kx}) + $signed({{(CW-3){dx_off[4]}}, dx_off});
    sy = $signed({2'b00, ky}) + $signed({{(CW-3){dy_off[4]}}, dy_off});

    inb_x = !sx[CW+1] && (sx <= X_MAX);
    inb_y = !sy[CW+1] && (sy <= Y_MAX);

    if (sx[CW+1])       cx = '0;
    else if (sx > X_MAX) cx = X_MAX[CW-1:0];
    else                cx = sx[CW-1:0];

    if (sy[CW+1])       cy = '0;
    else if (sy > Y_MAX) cy = Y_MAX[CW-1:0];
    else                cy = sy[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      kx        <= '0;
      ky        <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_idx   <= 8'd0;
      out_inb   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == FLUSH) && handshake;
      if (state == IDLE && start) begin
        kx  <= kp_x;
        ky  <= kp_y;
        cnt <= 8'd0;
      end
      if (advance) begin
        out_valid <= 1'b1;
        out_idx   <= cnt;
        out_x     <= cx;
        out_y     <= cy;
        out_inb   <= inb_x && inb_y;
        cnt       <= cnt + 8'd1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  // done is registered, so the done cycle is already back in IDLE.
  assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_win_addr_scan.sv
// Self-checking bench for win_addr_scan: ROM models, a scan-level reference
// model, per-cycle output compare, and randomized backpressure/start noise.
module tb_win_addr_scan;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int CW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] kp_x = '0;
  logic [CW-1:0] kp_y = '0;
  logic [7:0]    rom_addr;
  logic [4:0]    dx_off, dy_off;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_x, out_y;
  logic [7:0]    out_idx;
  logic          out_inb, busy, done;

  win_addr_scan #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kp_x(kp_x), .kp_y(kp_y),
    .rom_addr(rom_addr), .dx_off(dx_off), .dy_off(dy_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_idx(out_idx), .out_inb(out_inb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Offset ROMs: (8 - nibble) mod 32
  always_comb begin
    dx_off = 5'(5'd8 - {1'b0, rom_addr[3:0]});
    dy_off = 5'(5'd8 - {1'b0, rom_addr[7:4]});
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat for window index idx around keypoint (kx,ky).
  function automatic void beat(input int kx, input int ky, input int idx,
                               output int ex, output int ey, output int inb);
    int sx, sy;
    sx  = kx + 8 - (idx % 16);
    sy  = ky + 8 - (idx / 16);
    inb = (sx >= 0 && sx < IMG_W && sy >= 0 && sy < IMG_H) ? 1 : 0;
    ex  = (sx < 0) ? 0 : (sx > IMG_W - 1) ? IMG_W - 1 : sx;
    ey  = (sy < 0) ? 0 : (sy > IMG_H - 1) ? IMG_H - 1 : sy;
  endfunction

  // Scan-level model: phase 0 idle, 1 scanning, 2 done cycle.
  // Beats are valid from the second cycle of a scan until all 256 are taken.
  int m_phase = 0, m_age = 0, m_ptr = 0, m_kx = 0, m_ky = 0;
  int m_scans = 0, done_seen = 0;
  bit m_cleared = 1'b0, m_live = 1'b0;
  int rdy_pct = 100;

  always @(posedge clk) begin
    int prev;
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_ptr = 0; m_kx = 0; m_ky = 0;
      m_cleared = 1'b1; m_live = 1'b1;
    end else begin
      prev = m_phase;
      if (m_phase == 1) begin
        if (m_age >= 2 && out_ready) begin
          m_ptr++;
          if (m_ptr == 256) begin
            m_phase = 2;
            m_scans++;
          end
        end
        m_age++;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (prev != 1 && start) begin
        m_phase = 1; m_age = 1; m_ptr = 0;
        m_kx = int'(kp_x); m_ky = int'(kp_y);
        m_cleared = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int ex, ey, inb, erom;
    bit ev;
    if (m_live) begin
      ev   = (m_phase == 1) && (m_age >= 2);
      erom = (m_phase != 1 || m_age < 2 || m_ptr == 255) ? 0 : m_ptr + 1;
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("rom_addr", 32'(rom_addr), erom);
      if (ev) begin
        beat(m_kx, m_ky, m_ptr, ex, ey, inb);
        chk("out_idx", 32'(out_idx), m_ptr);
        chk("out_x", 32'(out_x), ex);
        chk("out_y", 32'(out_y), ey);
        chk("out_inb", 32'(out_inb), inb);
      end
      if (m_cleared) begin
        chk("rst_out_x", 32'(out_x), 0);
        chk("rst_out_y", 32'(out_y), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_inb", 32'(out_inb), 0);
      end
      if (done === 1'b1) done_seen++;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_scan(input int x, input int y, input int pct, input bit noise);
    int n;
    rdy_pct = pct;
    kp_x = CW'(x);
    kp_y = CW'(y);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (m_phase != 2 && n < 3000) begin
      if (noise) begin
        start = ($urandom_range(0, 15) == 0);
        kp_x  = CW'($urandom);
        kp_y  = CW'($urandom);
      end
      cyc();
      n++;
    end
    start = 1'b0;
    if (m_phase != 2) begin
      n_chk++;
      n_fail++;
      $display("FAIL scan_timeout: got %0d beats expected 256", m_ptr);
    end
    cyc();
  endtask

  initial begin
    int ex, ey, inb, n;
    // Pin the model with hand-computed values.
    beat(100, 50, 0, ex, ey, inb);
    chk("pin_nom0_x", ex, 108); chk("pin_nom0_y", ey, 58); chk("pin_nom0_inb", inb, 1);
    beat(100, 50, 255, ex, ey, inb);
    chk("pin_nom255_x", ex, 93); chk("pin_nom255_y", ey, 43); chk("pin_nom255_inb", inb, 1);
    beat(3, 3, 15, ex, ey, inb);
    chk("pin_left_x", ex, 0); chk("pin_left_y", ey, 11); chk("pin_left_inb", inb, 0);
    beat(3, 3, 0, ex, ey, inb);
    chk("pin_tl0_x", ex, 11); chk("pin_tl0_y", ey, 11); chk("pin_tl0_inb", inb, 1);
    beat(635, 475, 0, ex, ey, inb);
    chk("pin_br_x", ex, 639); chk("pin_br_y", ey, 479); chk("pin_br_inb", inb, 0);

    // Start held during reset must be ignored.
    rst_n = 1'b0; start = 1'b1; kp_x = 10'd5; kp_y = 10'd5;
    repeat (3) cyc();
    rst_n = 1'b1; start = 1'b0;
    repeat (2) cyc();

    do_scan(100, 50, 100, 1'b0);
    do_scan(3, 3, 100, 1'b0);
    do_scan(635, 475, 100, 1'b0);
    do_scan(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 30, 1'b1);

    // Reset in the middle of a scan, then a clean restart.
    rdy_pct = 100;
    kp_x = 10'd7; kp_y = 10'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (m_ptr < 100 && n < 1000) begin
      cyc();
      n++;
    end
    if (m_ptr < 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL reach_beat100: got %0d beats expected 100", m_ptr);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    do_scan(200, 300, 100, 1'b1);
    do_scan(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 50, 1'b1);
    do_scan(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 30, 1'b1);
    repeat (3) cyc();

    chk("done_count", done_seen, m_scans);
    chk("scan_count", m_scans, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/win_addr_scan.md
WIN_ADDR_SCAN -- requirements
Module: win_addr_scan

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, giving image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 480, giving image height in pixels.
REQ-003 The block SHALL have parameter CW, default 10, giving the coordinate width in bits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to scan the window of the presented keypoint.
REQ-007 kp_x  in  CW  keypoint column, unsigned, sampled on accepted start.
REQ-008 kp_y  in  CW  keypoint row, unsigned, sampled on accepted start.
REQ-009 rom_addr  out  8  window index {row[3:0], col[3:0]} driven to the external offset ROMs.
REQ-010 dx_off  in  5  signed column offset returned combinationally by the dx ROM for rom_addr.
REQ-011 dy_off  in  5  signed row offset returned combinationally by the dy ROM for rom_addr.
REQ-012 out_valid  out  1  output beat present.
REQ-013 out_ready  in  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-014 out_x  out  CW  clamped absolute sample column.
REQ-015 out_y  out  CW  clamped absolute sample row.
REQ-016 out_idx  out  8  window index of the beat.
REQ-017 out_inb  out  1  high when the unclamped sample lies inside the image.
REQ-018 busy  out  1  high from accepted start until the done cycle, inclusive.
REQ-019 done  out  1  one-cycle pulse when the scan is complete.

Function
REQ-020 The FSM SHALL have three states: IDLE, SCAN and FLUSH.
REQ-021 IDLE->SCAN on start=1: latch kp_x/kp_y, clear the index counter to 0; start in SCAN or FLUSH is ignored.
REQ-022 In SCAN, rom_addr SHALL equal the index counter; in IDLE and FLUSH it SHALL be 0.
REQ-023 Advance condition: state=SCAN and (out_valid=0 or out_ready=1).
REQ-024 On advance, the output register SHALL load: out_idx=counter, sx=kp_x+sext(dx_off), sy=kp_y+sext(dy_off), all computed at CW+2 bits signed; out_valid=1; counter increments.
REQ-025 out_inb SHALL be 1 iff 0<=sx<IMG_W and 0<=sy<IMG_H.
REQ-026 out_x SHALL be sx clamped to [0, IMG_W-1]; out_y SHALL be sy clamped to [0, IMG_H-1].
REQ-027 When the advance loads index 255, the next state SHALL be FLUSH; the counter wraps to 0 and is not reused.
REQ-028 In FLUSH, on handshake: out_valid=0, done=1 for one cycle, state->IDLE; busy=1 in that done cycle and 0 from the next cycle.
REQ-029 On handshake with no advance, out_valid SHALL go to 0; out_valid=1 with out_ready=0 SHALL hold all out_* stable.
REQ-030 Throughput SHALL be one beat per cycle under continuous out_ready=1: first out_valid two cycles after the start cycle, 256 beats back-to-back, done on the cycle after the index-255 handshake.
REQ-031 Latency from rom_addr to the registered output SHALL be exactly one cycle; the block SHALL contain no combinational path from out_ready to out_*.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE and counter=0; out_valid, done, busy, out_inb, out_x, out_y, out_idx, the latched keypoint and rom_addr all go to 0, including mid-scan; a pending beat is discarded.
REQ-033 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-034 Bench ROM models: dx_off = (8 - rom_addr[3:0]) mod 32; dy_off = (8 - rom_addr[7:4]) mod 32.
REQ-035 Nominal: kp=(100,50), out_ready=1 -> idx0 (108,58,inb=1), idx255 (93,43,inb=1); 256 consecutive beats; done exactly once; busy low afterwards.
REQ-036 Left/top edge: kp=(3,3) -> idx15 gives sx=-4 -> out_x=0, out_inb=0; idx0 gives (11,11), inb=1.
REQ-037 Right/bottom edge: kp=(635,475) -> idx0 gives sx=643, sy=483 -> (639,479), inb=0.
REQ-038 Backpressure: random out_ready at 30% -> beats stay stable while stalled; the idx sequence is 0..255 with no gaps or repeats; done follows the final handshake by one cycle.
REQ-039 Reset and re-start: rst_n=0 at beat 100 -> all outputs are 0 next cycle; start again -> a full 256-beat scan; start pulses during the scan have no effect.
